// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// Arbiter FSM states, requester ids and default bus widths.
package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 64;
    localparam int CPU_DATA_W = 64;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_MEM,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between IF (fetch) and MEM (load/store).
// Ports: if_* fetch side, mem_* load/store side, ram_* memory port.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W         = CPU_ADDR_W,
    parameter int DATA_W         = CPU_DATA_W,
    parameter int MAX_MEM_STREAK = 4,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam int WW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);
    // wdog holds the number of BUSY cycles already spent, so the
    // cycle with wdog == TIMEOUT_CYC-1 is the last one allowed.
    localparam logic [WW-1:0] WD_LAST =
        WW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [WW-1:0]     wdog_q, wdog_d;

    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic              if_done_q, if_done_d;
    logic              if_err_q, if_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              mem_done_q, mem_done_d;
    logic              mem_err_q, mem_err_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

    logic              if_forced;
    logic              wd_expire;

    assign if_forced = if_req && (streak_q == STREAK_MAX);
    assign wd_expire = (TIMEOUT_CYC != 0) && (wdog_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        wdog_d      = wdog_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        // Response outputs live for the RESP cycle only.
        if_done_d   = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        mem_done_d  = 1'b0;
        mem_err_d   = 1'b0;
        mem_rdata_d = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (!if_req) begin
                    streak_d = '0;
                end
                if (mem_req && !if_forced) begin
                    state_d     = ARB_BUSY_MEM;
                    owner_d     = OWN_MEM;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_we;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    wdog_d      = '0;
                    if (if_req && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (if_req) begin
                    state_d     = ARB_BUSY_IF;
                    owner_d     = OWN_IF;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                    wdog_d      = '0;
                    streak_d    = '0;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
                wdog_d = wdog_q + WW'(1);
                // ram_ready beats an expiring watchdog on the same cycle.
                if (ram_ready || wd_expire) begin
                    state_d   = ARB_RESP;
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    if (owner_q == OWN_MEM) begin
                        mem_done_d = 1'b1;
                        mem_err_d  = !ram_ready;
                        if (ram_ready && !ram_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_done_d = 1'b1;
                        if_err_d  = !ram_ready;
                        if (ram_ready) begin
                            if_rdata_d = ram_rdata;
                        end
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            wdog_q      <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_done_q   <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            mem_done_q  <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            wdog_q      <= wdog_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_done_q   <= if_done_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            mem_done_q  <= mem_done_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_done   = if_done_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_done  = mem_done_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle table plus multi-cycle sequences.
// Drives and samples on the falling clock edge.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req, mem_req, mem_we, ram_ready;
    logic [63:0] if_addr, mem_addr, mem_wdata, ram_rdata;
    logic [63:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
    logic        if_done, if_err, mem_done, mem_err;
    logic        ram_req, ram_we;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(64), .DATA_W(64),
        .MAX_MEM_STREAK(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err),
        .ram_req(ram_req), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    typedef struct packed {
        logic        rq;
        logic        we;
        logic [63:0] a;
        logic [63:0] wd;
        logic        ifd;
        logic        ife;
        logic [63:0] ifrd;
        logic        md;
        logic        me;
        logic [63:0] mrd;
    } out_t;

    typedef struct packed {
        logic        ifr;
        logic [63:0] ifa;
        logic        mr;
        logic        mw;
        logic [63:0] ma;
        logic [63:0] mdat;
        logic [63:0] rd;
        logic        rr;
    } in_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_at, busy;
    logic d_if, d_mem, d_err;
    logic [63:0] d_rd;
    logic [5:0]  gmem;

    function automatic in_t vi(
        logic ifr, logic [63:0] ifa, logic mr, logic mw,
        logic [63:0] ma, logic [63:0] mdat,
        logic [63:0] rd, logic rr);
        in_t v;
        v.ifr = ifr; v.ifa = ifa; v.mr = mr; v.mw = mw;
        v.ma = ma; v.mdat = mdat; v.rd = rd; v.rr = rr;
        return v;
    endfunction

    function automatic out_t vo(
        logic rq, logic we, logic [63:0] a, logic [63:0] wd,
        logic ifd, logic ife, logic [63:0] ifrd,
        logic md, logic me, logic [63:0] mrd);
        out_t v;
        v.rq = rq; v.we = we; v.a = a; v.wd = wd;
        v.ifd = ifd; v.ife = ife; v.ifrd = ifrd;
        v.md = md; v.me = me; v.mrd = mrd;
        return v;
    endfunction

    function automatic out_t cur();
        return vo(ram_req, ram_we, ram_addr, ram_wdata,
                  if_done, if_err, if_rdata,
                  mem_done, mem_err, mem_rdata);
    endfunction

    task automatic row(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        tv.push_back(v);
    endtask

    task automatic drive(input in_t i);
        if_req = i.ifr; if_addr = i.ifa;
        mem_req = i.mr; mem_we = i.mw;
        mem_addr = i.ma; mem_wdata = i.mdat;
        ram_rdata = i.rd; ram_ready = i.rr;
    endtask

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Caller drives the request on the current falling edge (cycle 0).
    // ready_at < 0 keeps ram_ready high, 0 never raises it.
    task automatic txn(input int ready_at);
        done_at = 0;
        busy = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ram_req) busy++;
            if (if_done || mem_done) begin
                done_at = k;
                d_if = if_done;
                d_mem = mem_done;
                d_err = if_err | mem_err;
                d_rd = if_done ? if_rdata : mem_rdata;
                ram_ready = 1'b0;
                break;
            end
            ram_ready = (ready_at < 0) || (k == ready_at);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        // IF-only fetch, zero-wait memory, ready also high in IDLE/RESP
        row(vi(1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0, 64'hDEAD, 1'b1),
            vo(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b1, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0, 64'hDEAD, 1'b1),
            vo(1'b1, 1'b0, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h40, 1'b0, 1'b0, 64'h0, 64'h0, 64'hDEAD, 1'b1),
            vo(1'b0, 1'b0, 64'h40, 64'h0, 1'b1, 1'b0, 64'hDEAD, 1'b0, 1'b0, 64'h0));
        // both request: MEM store first, then IF
        row(vi(1'b1, 64'h80, 1'b1, 1'b1, 64'h100, 64'h55, 64'h77, 1'b1),
            vo(1'b0, 1'b0, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b1, 64'h80, 1'b1, 1'b1, 64'h100, 64'h55, 64'h77, 1'b1),
            vo(1'b1, 1'b1, 64'h100, 64'h55, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b1, 64'h80, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1234, 1'b1),
            vo(1'b0, 1'b0, 64'h100, 64'h55, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0));
        row(vi(1'b1, 64'h80, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1234, 1'b1),
            vo(1'b0, 1'b0, 64'h100, 64'h55, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b1, 64'h80, 1'b0, 1'b0, 64'h0, 64'h0, 64'h1234, 1'b1),
            vo(1'b1, 1'b0, 64'h80, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0),
            vo(1'b0, 1'b0, 64'h80, 64'h0, 1'b1, 1'b0, 64'h1234, 1'b0, 1'b0, 64'h0));
        // MEM load with two wait states; address change after grant ignored
        row(vi(1'b0, 64'h0, 1'b1, 1'b0, 64'h200, 64'h0, 64'h0, 1'b0),
            vo(1'b0, 1'b0, 64'h80, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h0, 1'b1, 1'b0, 64'h300, 64'h0, 64'h0, 1'b0),
            vo(1'b1, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h0, 1'b1, 1'b0, 64'h300, 64'h0, 64'h0, 1'b0),
            vo(1'b1, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h0, 1'b1, 1'b0, 64'h300, 64'h0, 64'hBEEF, 1'b1),
            vo(1'b1, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0),
            vo(1'b0, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'hBEEF));
        // stray ready in IDLE gives nothing
        row(vi(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h5A, 1'b1),
            vo(1'b0, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));
        row(vi(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0),
            vo(1'b0, 1'b0, 64'h200, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0));

        drive(vi(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", 64'(cur() != '0), 64'd0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            n_vec++;
            if (cur() !== tv[i].o) begin
                n_bad++;
                $display("FAIL vec%0d: got %h want %h",
                         i, cur(), tv[i].o);
            end
            drive(tv[i].i);
        end

        // starvation guard: both held, expect M,M,M,M,I,M
        gmem = 6'b101111;
        @(negedge clk);
        if_req = 1'b1; if_addr = 64'h600;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h500;
        ram_rdata = 64'h11; ram_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            txn(-1);
            chk($sformatf("grant%0d", j), {62'd0, d_mem, d_if},
                gmem[j] ? 64'd2 : 64'd1);
        end
        if_req = 1'b0; mem_req = 1'b0; ram_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_streak", {63'd0, ram_req}, 64'd0);

        // watchdog expiry on a store
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h700;
        mem_wdata = 64'hAA; ram_rdata = 64'h5A5A; ram_ready = 1'b0;
        txn(0);
        mem_req = 1'b0;
        chk("to_done_at", 64'(done_at), 64'd9);
        chk("to_busy", 64'(busy), 64'd8);
        chk("to_mem_done", {63'd0, d_mem}, 64'd1);
        chk("to_err", {63'd0, d_err}, 64'd1);
        chk("to_rdata", d_rd, 64'd0);
        @(negedge clk);
        chk("to_idle", {61'd0, ram_req, if_done, mem_done}, 64'd0);

        // ready on the last watchdog cycle wins
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h800;
        ram_rdata = 64'hC0DE; ram_ready = 1'b0;
        txn(8);
        mem_req = 1'b0;
        chk("tie_done_at", 64'(done_at), 64'd9);
        chk("tie_err", {63'd0, d_err}, 64'd0);
        chk("tie_rdata", d_rd, 64'hC0DE);
        @(negedge clk);

        // reset in the middle of a MEM access
        mem_req = 1'b1; mem_addr = 64'h900;
        ram_rdata = 64'hF00D; ram_ready = 1'b0;
        @(negedge clk);
        chk("rst_busy1", {63'd0, ram_req}, 64'd1);
        @(negedge clk);
        chk("rst_busy2", {63'd0, ram_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'(cur() != '0), 64'd0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk($sformatf("rst_nodone%0d", j), {63'd0, mem_done}, 64'd0);
        end
        rst_n = 1'b1;
        txn(4);
        mem_req = 1'b0;
        chk("post_rst_done_at", 64'(done_at), 64'd5);
        chk("post_rst_mem", {63'd0, d_mem}, 64'd1);
        chk("post_rst_err", {63'd0, d_err}, 64'd0);
        chk("post_rst_rdata", d_rd, 64'hF00D);
        chk("post_rst_busy", 64'(busy), 64'd4);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
